// File: rtl/graphics_command_decoder_if.sv
// Command-stream and pixel/palette bus between the SPI register block, the
// command decoder, the frame buffer and the colour palette.
interface graphics_command_decoder_if;
   logic [7:0]  op_code_in;
   logic        op_code_valid_in;
   logic [7:0]  operand_in;
   logic        operand_valid_in;
   logic        busy_out;
   logic [17:0] pixel_write_address_out;
   logic [3:0]  pixel_write_data_out;
   logic        pixel_write_enable_out;
   logic        pixel_write_buffer_ready_in;
   logic        switch_write_buffer_out;
   logic        assign_color_enable_out;
   logic [3:0]  assign_color_index_out;
   logic [9:0]  assign_color_value_out;

   // Command source / frame-buffer side.
   modport master (
      output op_code_in, op_code_valid_in, operand_in, operand_valid_in,
      output pixel_write_buffer_ready_in,
      input  busy_out, pixel_write_address_out, pixel_write_data_out,
      input  pixel_write_enable_out, switch_write_buffer_out,
      input  assign_color_enable_out, assign_color_index_out, assign_color_value_out
   );

   // Decoder side.
   modport slave (
      input  op_code_in, op_code_valid_in, operand_in, operand_valid_in,
      input  pixel_write_buffer_ready_in,
      output busy_out, pixel_write_address_out, pixel_write_data_out,
      output pixel_write_enable_out, switch_write_buffer_out,
      output assign_color_enable_out, assign_color_index_out, assign_color_value_out
   );
endinterface

// File: rtl/graphics_command_decoder.sv
// Byte-serial graphics command decoder: collects op code operands, issues
// palette assignments and buffer swaps, and runs clipped rectangle fills in
// raster order against a back-pressured frame buffer.
module graphics_command_decoder #(
   parameter int unsigned SCREEN_WIDTH  = 640,
   parameter int unsigned SCREEN_HEIGHT = 400
) (
   input logic                       clock_in,
   input logic                       reset_in,
   graphics_command_decoder_if.slave bus
);

   localparam logic [7:0] OpAssignColor = 8'h10;
   localparam logic [7:0] OpFillRect    = 8'h12;
   localparam logic [7:0] OpSwitch      = 8'h14;
   localparam logic [7:0] OpClear       = 8'h16;

   localparam logic [15:0] Width16  = 16'(SCREEN_WIDTH);
   localparam logic [15:0] Height16 = 16'(SCREEN_HEIGHT);
   localparam logic [16:0] Width17  = 17'(SCREEN_WIDTH);
   localparam logic [16:0] Height17 = 17'(SCREEN_HEIGHT);
   localparam logic [17:0] Width18  = 18'(SCREEN_WIDTH);

   typedef enum logic [1:0] {StIdle, StCollect, StClip, StDraw} state_e;

   state_e      state_q;
   logic [7:0]  op_q;
   logic [3:0]  cnt_q;
   logic [15:0] x_q, y_q, w_q, h_q;
   logic [3:0]  color_q;
   logic [3:0]  ac_index_q;
   logic [1:0]  ac_hi_q;

   // Raster walk state
   logic [15:0] cur_x_q, cur_y_q, x_start_q, x_end_q, y_end_q;
   logic [17:0] row_base_q;

   // Registered outputs
   logic        busy_q;
   logic [17:0] addr_q;
   logic [3:0]  data_q;
   logic        switch_q;
   logic        ac_en_q;
   logic [3:0]  ac_idx_out_q;
   logic [9:0]  ac_val_q;

   // Clip results
   logic [16:0] x_sum, y_sum;
   logic [15:0] x_end_c, y_end_c;
   logic        clip_empty;
   logic [17:0] row_base_c;

   // Clip window and the one row-base multiply, consumed only in StClip.
   always_comb begin
      x_sum      = {1'b0, x_q} + {1'b0, w_q};
      y_sum      = {1'b0, y_q} + {1'b0, h_q};
      x_end_c    = (x_sum > Width17) ? Width16 : x_sum[15:0];
      y_end_c    = (y_sum > Height17) ? Height16 : y_sum[15:0];
      clip_empty = (x_q >= Width16) || (y_q >= Height16) || (w_q == '0) || (h_q == '0);
      row_base_c = 18'(y_q) * Width18;
   end

   // Command FSM with registered outputs.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= StIdle;
         op_q         <= '0;
         cnt_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         w_q          <= '0;
         h_q          <= '0;
         color_q      <= '0;
         ac_index_q   <= '0;
         ac_hi_q      <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         x_start_q    <= '0;
         x_end_q      <= '0;
         y_end_q      <= '0;
         row_base_q   <= '0;
         busy_q       <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         switch_q     <= 1'b0;
         ac_en_q      <= 1'b0;
         ac_idx_out_q <= '0;
         ac_val_q     <= '0;
      end else begin
         switch_q <= 1'b0;
         ac_en_q  <= 1'b0;
         unique case (state_q)
            StIdle, StCollect: begin
               // A new op code always wins and restarts collection.
               if (bus.op_code_valid_in) begin
                  cnt_q <= '0;
                  op_q  <= bus.op_code_in;
                  case (bus.op_code_in)
                     OpAssignColor, OpFillRect: state_q <= StCollect;
                     OpSwitch: begin
                        switch_q <= 1'b1;
                        state_q  <= StIdle;
                     end
                     OpClear: begin
                        x_q     <= '0;
                        y_q     <= '0;
                        w_q     <= Width16;
                        h_q     <= Height16;
                        color_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StClip;
                     end
                     default: state_q <= StIdle;
                  endcase
               end else if (bus.operand_valid_in && (state_q == StCollect)) begin
                  cnt_q <= cnt_q + 4'd1;
                  if (op_q == OpAssignColor) begin
                     case (cnt_q)
                        4'd0: ac_index_q <= bus.operand_in[3:0];
                        4'd1: ac_hi_q    <= bus.operand_in[1:0];
                        default: begin
                           ac_en_q      <= 1'b1;
                           ac_idx_out_q <= ac_index_q;
                           ac_val_q     <= {ac_hi_q, bus.operand_in};
                           state_q      <= StIdle;
                        end
                     endcase
                  end else begin
                     case (cnt_q)
                        4'd0: x_q[15:8] <= bus.operand_in;
                        4'd1: x_q[7:0]  <= bus.operand_in;
                        4'd2: y_q[15:8] <= bus.operand_in;
                        4'd3: y_q[7:0]  <= bus.operand_in;
                        4'd4: w_q[15:8] <= bus.operand_in;
                        4'd5: w_q[7:0]  <= bus.operand_in;
                        4'd6: h_q[15:8] <= bus.operand_in;
                        4'd7: h_q[7:0]  <= bus.operand_in;
                        default: begin
                           color_q <= bus.operand_in[3:0];
                           busy_q  <= 1'b1;
                           state_q <= StClip;
                        end
                     endcase
                  end
               end
            end
            StClip: begin
               if (clip_empty) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cur_x_q    <= x_q;
                  cur_y_q    <= y_q;
                  x_start_q  <= x_q;
                  x_end_q    <= x_end_c;
                  y_end_q    <= y_end_c;
                  row_base_q <= row_base_c;
                  addr_q     <= row_base_c + 18'(x_q);
                  data_q     <= color_q;
                  state_q    <= StDraw;
               end
            end
            StDraw: begin
               // Advance only on cycles the frame buffer accepted the pixel.
               if (bus.pixel_write_buffer_ready_in) begin
                  if (cur_x_q + 16'd1 == x_end_q) begin
                     if (cur_y_q + 16'd1 == y_end_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                     end else begin
                        cur_y_q    <= cur_y_q + 16'd1;
                        cur_x_q    <= x_start_q;
                        row_base_q <= row_base_q + Width18;
                        addr_q     <= row_base_q + Width18 + 18'(x_start_q);
                     end
                  end else begin
                     cur_x_q <= cur_x_q + 16'd1;
                     addr_q  <= addr_q + 18'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy_out                = busy_q;
   assign bus.pixel_write_address_out = addr_q;
   assign bus.pixel_write_data_out    = data_q;
   // Gated by ready so a stalled frame buffer never sees a strobe.
   assign bus.pixel_write_enable_out  = (state_q == StDraw) && bus.pixel_write_buffer_ready_in;
   assign bus.switch_write_buffer_out = switch_q;
   assign bus.assign_color_enable_out = ac_en_q;
   assign bus.assign_color_index_out  = ac_idx_out_q;
   assign bus.assign_color_value_out  = ac_val_q;

endmodule

// File: tb/tb_graphics_command_decoder.sv
// Directed bench for graphics_command_decoder: table-driven palette and fill
// vectors plus hand-written abort, busy, same-cycle and reset sequences.
module tb_graphics_command_decoder;
   localparam int unsigned W = 640;
   localparam int unsigned H = 400;

   logic clock_in = 1'b0;
   logic reset_in = 1'b0;

   graphics_command_decoder_if bus();

   graphics_command_decoder #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 clock_in = ~clock_in;

   typedef struct {
      logic [7:0] b0, b1, b2;
      logic [3:0] idx;
      logic [9:0] val;
   } ac_vec_t;

   typedef struct {
      logic [15:0] x, y, w, h;
      logic [3:0]  color;
      logic [7:0]  ready_pat;
      int          exp_writes;
      int          exp_first;
      int          exp_last;
   } fill_vec_t;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int last_strobe_cyc = 0;
   logic [7:0] rdy_pat = 8'hFF;

   // Write / pulse monitor, sampled on the falling edge
   logic [17:0] wr_addr[$];
   logic [3:0]  wr_data[$];
   int          wr_cyc[$];
   int en_bad = 0, busy_cnt = 0, busy_last = 0, switch_cnt = 0, ac_cnt = 0;

   always @(posedge clock_in) cyc <= cyc + 1;

   always @(negedge clock_in) begin
      if (bus.pixel_write_enable_out) begin
         wr_addr.push_back(bus.pixel_write_address_out);
         wr_data.push_back(bus.pixel_write_data_out);
         wr_cyc.push_back(cyc);
         if (!bus.pixel_write_buffer_ready_in) en_bad = en_bad + 1;
      end
      if (bus.busy_out) begin
         busy_cnt  = busy_cnt + 1;
         busy_last = cyc;
      end
      if (bus.switch_write_buffer_out) switch_cnt = switch_cnt + 1;
      if (bus.assign_color_enable_out) ac_cnt = ac_cnt + 1;
   end

   // Frame-buffer ready follows an 8-cycle pattern
   initial begin
      bus.pixel_write_buffer_ready_in = 1'b1;
      forever begin
         @(posedge clock_in);
         #1 bus.pixel_write_buffer_ready_in = rdy_pat[cyc % 8];
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      total = total + 1;
      if (act == exp) passed = passed + 1;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic send_op(input logic [7:0] op);
      @(posedge clock_in);
      #1;
      bus.op_code_in = op;
      bus.op_code_valid_in = 1'b1;
      last_strobe_cyc = cyc;
      @(posedge clock_in);
      #1 bus.op_code_valid_in = 1'b0;
   endtask

   task automatic send_opnd(input logic [7:0] b);
      @(posedge clock_in);
      #1;
      bus.operand_in = b;
      bus.operand_valid_in = 1'b1;
      last_strobe_cyc = cyc;
      @(posedge clock_in);
      #1 bus.operand_valid_in = 1'b0;
   endtask

   task automatic send_both(input logic [7:0] op, input logic [7:0] b);
      @(posedge clock_in);
      #1;
      bus.op_code_in = op;
      bus.operand_in = b;
      bus.op_code_valid_in = 1'b1;
      bus.operand_valid_in = 1'b1;
      @(posedge clock_in);
      #1;
      bus.op_code_valid_in = 1'b0;
      bus.operand_valid_in = 1'b0;
   endtask

   task automatic send_fill(input logic [15:0] x, y, w, h, input logic [3:0] c);
      send_op(8'h12);
      send_opnd(x[15:8]); send_opnd(x[7:0]);
      send_opnd(y[15:8]); send_opnd(y[7:0]);
      send_opnd(w[15:8]); send_opnd(w[7:0]);
      send_opnd(h[15:8]); send_opnd(h[7:0]);
      send_opnd({4'h0, c});
   endtask

   task automatic wait_not_busy(input string name);
      int expired = 1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clock_in);
         #1;
         if (!bus.busy_out) begin
            expired = 0;
            break;
         end
      end
      check({name, "_timeout"}, expired, 0);
   endtask

   task automatic run_ac(input ac_vec_t v, input int k);
      int b_ac = ac_cnt;
      send_op(8'h10);
      send_opnd(v.b0);
      send_opnd(v.b1);
      send_opnd(v.b2);
      check($sformatf("ac%0d_en", k), bus.assign_color_enable_out, 1);
      check($sformatf("ac%0d_idx", k), bus.assign_color_index_out, v.idx);
      check($sformatf("ac%0d_val", k), bus.assign_color_value_out, v.val);
      @(posedge clock_in);
      #1;
      check($sformatf("ac%0d_en_drop", k), bus.assign_color_enable_out, 0);
      check($sformatf("ac%0d_pulses", k), ac_cnt - b_ac, 1);
   endtask

   task automatic run_fill(input fill_vec_t v, input int k);
      int base = wr_addr.size();
      int b_busy = busy_cnt;
      int b_bad = en_bad;
      int n, m, xe, ye, a_bad, d_bad;
      rdy_pat = v.ready_pat;
      send_fill(v.x, v.y, v.w, v.h, v.color);
      wait_not_busy($sformatf("fill%0d", k));
      n = wr_addr.size() - base;
      check($sformatf("fill%0d_writes", k), n, v.exp_writes);
      // Reference raster walk with a per-pixel multiply
      xe = (int'(v.x) + int'(v.w) > W) ? W : int'(v.x) + int'(v.w);
      ye = (int'(v.y) + int'(v.h) > H) ? H : int'(v.y) + int'(v.h);
      m = 0; a_bad = 0; d_bad = 0;
      if (v.x < W && v.y < H && v.w != 0 && v.h != 0) begin
         for (int yy = int'(v.y); yy < ye; yy++) begin
            for (int xx = int'(v.x); xx < xe; xx++) begin
               if (m < n) begin
                  if (int'(wr_addr[base + m]) != yy * W + xx) a_bad++;
                  if (wr_data[base + m] != v.color) d_bad++;
               end
               m++;
            end
         end
      end
      check($sformatf("fill%0d_addr_seq", k), a_bad, 0);
      check($sformatf("fill%0d_data", k), d_bad, 0);
      check($sformatf("fill%0d_en_no_ready", k), en_bad - b_bad, 0);
      if (v.exp_writes == 0) begin
         check($sformatf("fill%0d_busy_cycles", k), busy_cnt - b_busy, 1);
      end else if (n > 0) begin
         check($sformatf("fill%0d_first", k), wr_addr[base], v.exp_first);
         check($sformatf("fill%0d_last", k), wr_addr[base + n - 1], v.exp_last);
         check($sformatf("fill%0d_busy_fall", k), busy_last, wr_cyc[base + n - 1]);
         if (v.ready_pat == 8'hFF) begin
            check($sformatf("fill%0d_latency", k), wr_cyc[base] - last_strobe_cyc, 2);
            check($sformatf("fill%0d_back_to_back", k),
                  wr_cyc[base + n - 1] - wr_cyc[base], n - 1);
         end
      end
      rdy_pat = 8'hFF;
   endtask

   ac_vec_t   acs[4];
   fill_vec_t fills[9];

   initial begin
      int b_wr, b_sw, b_ac, b_busy;

      acs[0] = '{8'h05, 8'h02, 8'hAB, 4'h5, 10'h2AB};
      acs[1] = '{8'hFF, 8'hFF, 8'hFF, 4'hF, 10'h3FF};
      acs[2] = '{8'h13, 8'h04, 8'h00, 4'h3, 10'h000};
      acs[3] = '{8'h0A, 8'hFD, 8'h12, 4'hA, 10'h112};

      fills[0] = '{16'd10,  16'd5,   16'd2, 16'd2, 4'd3,  8'hFF,       4, 3210,   3851};
      fills[1] = '{16'd638, 16'd399, 16'd5, 16'd5, 4'd7,  8'hFF,       2, 255998, 255999};
      fills[2] = '{16'd700, 16'd5,   16'd3, 16'd3, 4'd1,  8'hFF,       0, 0,      0};
      fills[3] = '{16'd10,  16'd5,   16'd0, 16'd2, 4'd1,  8'hFF,       0, 0,      0};
      fills[4] = '{16'd5,   16'd400, 16'd2, 16'd2, 4'd1,  8'hFF,       0, 0,      0};
      fills[5] = '{16'd10,  16'd5,   16'd2, 16'd2, 4'd9,  8'b10011001, 4, 3210,   3851};
      fills[6] = '{16'd0,   16'd0,   16'd3, 16'd1, 4'd15, 8'hFF,       3, 0,      2};
      fills[7] = '{16'd100, 16'd10,  16'd1, 16'd3, 4'd4,  8'b01010101, 3, 6500,   7780};
      fills[8] = '{16'd20,  16'd2,   16'd0, 16'd0, 4'd2,  8'hFF,       0, 0,      0};

      bus.op_code_in = '0;
      bus.op_code_valid_in = 1'b0;
      bus.operand_in = '0;
      bus.operand_valid_in = 1'b0;

      #2 reset_in = 1'b1;
      #18;
      check("rst_busy", bus.busy_out, 0);
      check("rst_en", bus.pixel_write_enable_out, 0);
      check("rst_addr", bus.pixel_write_address_out, 0);
      check("rst_switch", bus.switch_write_buffer_out, 0);
      check("rst_ac_en", bus.assign_color_enable_out, 0);
      check("rst_ac_val", bus.assign_color_value_out, 0);
      @(negedge clock_in);
      reset_in = 1'b0;

      foreach (acs[i]) run_ac(acs[i], i);
      foreach (fills[i]) run_fill(fills[i], i);

      // FILL_RECT aborted by SWITCH_BUFFER after 4 operands; the tail is stray
      b_wr = wr_addr.size(); b_sw = switch_cnt; b_busy = busy_cnt;
      send_op(8'h12);
      send_opnd(8'h00); send_opnd(8'h00); send_opnd(8'h00); send_opnd(8'h00);
      send_op(8'h14);
      check("abort_switch_now", bus.switch_write_buffer_out, 1);
      send_opnd(8'h00); send_opnd(8'h02); send_opnd(8'h00); send_opnd(8'h02);
      send_opnd(8'h05);
      repeat (4) @(posedge clock_in);
      #1;
      check("abort_switch_pulses", switch_cnt - b_sw, 1);
      check("abort_writes", wr_addr.size() - b_wr, 0);
      check("abort_busy", busy_cnt - b_busy, 0);

      // Op codes and operands while a 4x4 fill is drawing are ignored
      b_wr = wr_addr.size(); b_sw = switch_cnt; b_ac = ac_cnt;
      send_fill(16'd0, 16'd0, 16'd4, 16'd4, 4'd2);
      send_op(8'h14);
      send_op(8'h10);
      send_opnd(8'h01); send_opnd(8'h03); send_opnd(8'hFF);
      wait_not_busy("busy_ignore");
      check("busy_ignore_writes", wr_addr.size() - b_wr, 16);
      check("busy_ignore_switch", switch_cnt - b_sw, 0);
      check("busy_ignore_ac", ac_cnt - b_ac, 0);

      // Unknown op code, then operands in IDLE: nothing happens
      b_wr = wr_addr.size(); b_ac = ac_cnt; b_sw = switch_cnt;
      send_op(8'h33);
      send_opnd(8'h05); send_opnd(8'h02); send_opnd(8'hAB);
      repeat (3) @(posedge clock_in);
      #1;
      check("unknown_op_ac", ac_cnt - b_ac, 0);
      check("unknown_op_writes", wr_addr.size() - b_wr, 0);
      check("unknown_op_switch", switch_cnt - b_sw, 0);

      // Op code and operand together: op code restarts, operand dropped
      b_ac = ac_cnt;
      send_op(8'h10);
      send_opnd(8'h0E);
      send_both(8'h10, 8'h07);
      send_opnd(8'h03);
      send_opnd(8'h01);
      check("both_no_early_pulse", ac_cnt - b_ac, 0);
      send_opnd(8'h22);
      check("both_en", bus.assign_color_enable_out, 1);
      check("both_idx", bus.assign_color_index_out, 3);
      check("both_val", bus.assign_color_value_out, 10'h122);

      // CLEAR interrupted by reset after 100 writes
      b_wr = wr_addr.size();
      send_op(8'h16);
      for (int i = 0; i < 400 && (wr_addr.size() - b_wr) < 100; i++) begin
         @(negedge clock_in);
         #1;
      end
      check("clear_writes_before_reset", wr_addr.size() - b_wr, 100);
      check("clear_addr99", wr_addr[b_wr + 99], 99);
      reset_in = 1'b1;
      #1;
      check("mid_rst_en", bus.pixel_write_enable_out, 0);
      check("mid_rst_busy", bus.busy_out, 0);
      check("mid_rst_addr", bus.pixel_write_address_out, 0);
      check("mid_rst_ac_idx", bus.assign_color_index_out, 0);
      check("mid_rst_ac_val", bus.assign_color_value_out, 0);
      repeat (3) @(negedge clock_in);
      reset_in = 1'b0;
      repeat (5) @(posedge clock_in);
      #1;
      check("post_rst_no_writes", wr_addr.size() - b_wr, 100);
      check("post_rst_busy", bus.busy_out, 0);
      run_ac('{8'h0C, 8'h03, 8'h5A, 4'hC, 10'h35A}, 9);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
